// File: rtl/interval_timer.sv
// interval_timer: memory-mapped interval timer on the processor bus.
//
// The processor programs the reload value (LOAD) and the control bits (CTRL)
// through the store path. It reads the live count and the status back through
// the registered DIN read path, which has one cycle of latency.
//
// Ports
//   Clock   in   1  system clock, rising edge
//   Resetn  in   1  synchronous active-low reset
//   cs      in   1  chip select (ADDR[15:12]==4'h4, decoded outside)
//   W       in   1  write strobe; a register write happens on cs & W
//   ADDR    in   2  register select: 0 LOAD, 1 CTRL, 2 COUNT, 3 STATUS
//   DOUT    in  16  processor write data
//   Q       out 16  registered read data of the register selected last cycle
//   Done    out  1  sticky terminal-count flag (STATUS[0])
module interval_timer #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        cs,
  input  logic        W,
  input  logic [1:0]  ADDR,
  input  logic [15:0] DOUT,
  output logic [15:0] Q,
  output logic        Done
);

  localparam logic [1:0]  A_LOAD   = 2'd0;
  localparam logic [1:0]  A_CTRL   = 2'd1;
  localparam logic [1:0]  A_COUNT  = 2'd2;
  localparam logic [1:0]  A_STATUS = 2'd3;
  localparam logic [25:0] PC_LAST  = 26'(PRESCALE - 1);

  logic [15:0] load_q, load_d;
  logic [15:0] count_q, count_d;
  logic [15:0] rdata_q, rdata_d;
  logic [25:0] pc_q, pc_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        done_q, done_d;

  logic wr_load, wr_ctrl, wr_count, wr_status;
  logic tick, done_set;

  always_comb begin
    wr_load   = cs & W & (ADDR == A_LOAD);
    wr_ctrl   = cs & W & (ADDR == A_CTRL);
    wr_count  = cs & W & (ADDR == A_COUNT);
    wr_status = cs & W & (ADDR == A_STATUS);
    tick      = en_q & (pc_q == PC_LAST);
  end

  // Prescaler: free-runs 0..PRESCALE-1 while enabled. It is pinned at 0 while
  // disabled, so the first tick after enabling comes a full PRESCALE cycles
  // later.
  always_comb begin
    pc_d = pc_q;
    if (!en_q || tick) pc_d = '0;
    else               pc_d = pc_q + 26'd1;
    // A restart, or an EN change, re-phases the prescaler.
    if (wr_count || (wr_ctrl && (DOUT[0] != en_q))) pc_d = '0;
  end

  // Count / control / status next state. The tick update uses the pre-write
  // EN. Bus writes are applied afterwards so that they win where the two
  // collide. The one exception is DONE set, which beats a STATUS clear.
  always_comb begin
    load_d   = load_q;
    count_d  = count_q;
    en_d     = en_q;
    auto_d   = auto_q;
    done_d   = done_q;
    done_set = 1'b0;

    if (tick) begin
      if (count_q > 16'd1) begin
        count_d = count_q - 16'd1;
      end else if (count_q == 16'd1) begin
        count_d  = '0;
        done_set = 1'b1;
        if (!auto_q) en_d = 1'b0;
      end else if (auto_q) begin
        // Reload from zero adds one tick to every auto period and is not a
        // DONE event.
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // A restart supersedes this cycle's tick entirely, including its DONE.
    if (wr_count) begin
      count_d  = load_q;
      en_d     = en_q;
      done_set = 1'b0;
    end

    if (wr_ctrl) begin
      en_d   = DOUT[0];
      auto_d = DOUT[1];
    end

    // The reload above already sampled load_q, so a same-cycle LOAD write
    // only affects the next reload.
    if (wr_load) load_d = DOUT;

    if (wr_status && DOUT[0]) done_d = 1'b0;
    if (done_set)             done_d = 1'b1;
  end

  // Read data is registered: Q shows the register that ADDR selected in the
  // previous cycle, with its value from before that edge.
  always_comb begin
    rdata_d = load_q;
    case (ADDR)
      A_LOAD:   rdata_d = load_q;
      A_CTRL:   rdata_d = {14'd0, auto_q, en_q};
      A_COUNT:  rdata_d = count_q;
      A_STATUS: rdata_d = {15'd0, done_q};
      default:  rdata_d = load_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      load_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      pc_q    <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
    end
  end

  assign Q    = rdata_q;
  assign Done = done_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer with PRESCALE=2.
//
// Every driven cycle pushes one expectation onto a scoreboard queue. The
// expectation covers Q, which is the register selected during that cycle, and
// Done, which is the value after the edge. A monitor pops one entry after each
// rising edge and compares it against the DUT outputs.
module tb_interval_timer;

  logic        Clock  = 1'b0;
  logic        Resetn = 1'b0;
  logic        cs     = 1'b0;
  logic        W      = 1'b0;
  logic [1:0]  ADDR   = 2'd0;
  logic [15:0] DOUT   = 16'd0;
  logic [15:0] Q;
  logic        Done;

  interval_timer #(.PRESCALE(2)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .cs     (cs),
    .W      (W),
    .ADDR   (ADDR),
    .DOUT   (DOUT),
    .Q      (Q),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        chk_q;
    logic [15:0] exp_q;
    logic        chk_dn;
    logic        exp_dn;
    string       name;
  } exp_t;

  typedef struct {
    logic        rstn;
    logic        c;
    logic        w;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp_q;
    logic        exp_dn;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t tv[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic drive(input logic rstn, input logic c, input logic w,
                       input logic [1:0] a, input logic [15:0] d,
                       input logic cq, input logic [15:0] eq,
                       input logic cd, input logic ed, input string nm);
    exp_t e;
    @(negedge Clock);
    Resetn = rstn; cs = c; W = w; ADDR = a; DOUT = d;
    e.chk_q = cq; e.exp_q = eq; e.chk_dn = cd; e.exp_dn = ed; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d,
                    input logic [15:0] eq, input logic ed, input string nm);
    drive(1'b1, 1'b1, 1'b1, a, d, 1'b1, eq, 1'b1, ed, nm);
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] eq,
                    input logic ed, input string nm);
    drive(1'b1, 1'b1, 1'b0, a, 16'd0, 1'b1, eq, 1'b1, ed, nm);
  endtask

  task automatic t_add(input logic rstn, input logic c, input logic w,
                       input logic [1:0] a, input logic [15:0] d,
                       input logic [15:0] eq, input logic ed, input string nm);
    vec_t v;
    v.rstn = rstn; v.c = c; v.w = w; v.a = a; v.d = d;
    v.exp_q = eq; v.exp_dn = ed; v.name = nm;
    tv.push_back(v);
  endtask

  // Monitor: the entry pushed before an edge is checked just after it.
  initial begin : mon
    exp_t m;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        if (m.chk_q)  check16({m.name, " Q"}, Q, m.exp_q);
        if (m.chk_dn) check16({m.name, " Done"}, {15'd0, Done}, {15'd0, m.exp_dn});
      end
    end
  end

  initial begin : stim
    // Reset with random bus traffic, then readback of every register.
    t_add(0, 1, 1'($urandom), 2'($urandom), 16'($urandom), 16'h0000, 0, "rst0");
    t_add(0, 1, 1'($urandom), 2'($urandom), 16'($urandom), 16'h0000, 0, "rst1");
    t_add(1, 1, 0, 2'd0, 16'd0, 16'h0000, 0, "rst load");
    t_add(1, 1, 0, 2'd1, 16'd0, 16'h0000, 0, "rst ctrl");
    t_add(1, 1, 0, 2'd2, 16'd0, 16'h0000, 0, "rst count");
    t_add(1, 1, 0, 2'd3, 16'd0, 16'h0000, 0, "rst status");
    // Read path: write LOAD, then read it back. Write CTRL all-ones. With
    // COUNT=0 and AUTO=1, the tick reloads COUNT from LOAD and sets no DONE.
    t_add(1, 1, 1, 2'd0, 16'hBEEF, 16'h0000, 0, "wr load old");
    t_add(1, 1, 0, 2'd0, 16'd0,    16'hBEEF, 0, "rd load");
    t_add(1, 1, 1, 2'd1, 16'hFFFF, 16'h0000, 0, "wr ctrl old");
    t_add(1, 1, 0, 2'd1, 16'd0,    16'h0003, 0, "rd ctrl mask");
    t_add(1, 1, 1, 2'd1, 16'h0000, 16'h0003, 0, "ctrl off");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'hBEEF, 0, "reload from 0");
    t_add(1, 1, 0, 2'd1, 16'd0,    16'h0000, 0, "ctrl cleared");
    // One-shot with LOAD=3.
    t_add(1, 1, 1, 2'd0, 16'd3,    16'hBEEF, 0, "os load");
    t_add(1, 1, 1, 2'd2, 16'd0,    16'hBEEF, 0, "os restart");
    t_add(1, 1, 1, 2'd1, 16'd1,    16'h0000, 0, "os enable");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd3, 0, "os c1");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd3, 0, "os c2");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd2, 0, "os c3");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd2, 0, "os c4");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd1, 0, "os c5");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd1, 1, "os c6");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd0, 1, "os c7");
    t_add(1, 1, 0, 2'd1, 16'd0,    16'd0, 1, "os ctrl stop");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd0, 1, "os hold0");
    t_add(1, 1, 0, 2'd2, 16'd0,    16'd0, 1, "os hold1");
    t_add(1, 1, 0, 2'd3, 16'd0,    16'd1, 1, "os status");
    t_add(1, 1, 1, 2'd3, 16'd0,    16'd1, 1, "status wr0 noop");
    t_add(1, 1, 1, 2'd3, 16'd1,    16'd1, 0, "status clear");
    t_add(1, 1, 0, 2'd3, 16'd0,    16'd0, 0, "status cleared");

    foreach (tv[i])
      drive(tv[i].rstn, tv[i].c, tv[i].w, tv[i].a, tv[i].d,
            1'b1, tv[i].exp_q, 1'b1, tv[i].exp_dn, tv[i].name);

    // Auto-reload with LOAD=2. The first period is 2 ticks and later periods
    // are 3 ticks (6 cycles).
    wr(2'd0, 16'd2, 16'd3, 0, "ar load");
    wr(2'd2, 16'd0, 16'd0, 0, "ar restart");
    wr(2'd1, 16'd3, 16'd0, 0, "ar enable");
    rd(2'd3, 16'd0, 0, "ar s1");
    rd(2'd3, 16'd0, 0, "ar s2");
    rd(2'd3, 16'd0, 0, "ar s3");
    rd(2'd3, 16'd0, 1, "ar first done");
    wr(2'd3, 16'd1, 16'd1, 0, "ar clear");
    rd(2'd2, 16'd0, 0, "ar cnt0");
    rd(2'd2, 16'd2, 0, "ar reload a");
    rd(2'd2, 16'd2, 0, "ar reload b");
    rd(2'd2, 16'd1, 0, "ar cnt1");
    rd(2'd2, 16'd1, 1, "ar second done");

    // STATUS clear in the same cycle as the 1->0 tick: DONE must stay set.
    wr(2'd3, 16'd1, 16'd1, 0, "col clear");
    for (int i = 0; i < 4; i++) rd(2'd3, 16'd0, 0, "col wait");
    wr(2'd3, 16'd1, 16'd0, 1, "col set beats clear");
    rd(2'd3, 16'd1, 1, "col status");

    // COUNT write in a tick cycle with COUNT=1: restart wins, no DONE.
    wr(2'd3, 16'd1, 16'd1, 0, "rs clear");
    rd(2'd2, 16'd2, 0, "rs c2a");
    rd(2'd2, 16'd2, 0, "rs c2b");
    rd(2'd2, 16'd1, 0, "rs c1");
    wr(2'd2, 16'd0, 16'd1, 0, "rs restart in tick");
    rd(2'd2, 16'd2, 0, "rs count reloaded");
    rd(2'd3, 16'd0, 0, "rs no done");
    wr(2'd1, 16'd0, 16'd3, 0, "rs stop");

    // Reset during a count: everything returns to zero and DONE never rises.
    wr(2'd0, 16'd5, 16'd2, 0, "mr load");
    wr(2'd2, 16'd0, 16'd1, 0, "mr restart");
    wr(2'd1, 16'd1, 16'd0, 0, "mr enable");
    rd(2'd2, 16'd5, 0, "mr c5a");
    rd(2'd2, 16'd5, 0, "mr c5b");
    rd(2'd2, 16'd4, 0, "mr c4a");
    rd(2'd2, 16'd4, 0, "mr c4b");
    drive(1'b0, 1'b1, 1'b1, 2'($urandom), 16'($urandom), 1'b1, 16'd0, 1'b1, 1'b0, "mr reset");
    rd(2'd0, 16'd0, 0, "mr load0");
    rd(2'd1, 16'd0, 0, "mr ctrl0");
    rd(2'd2, 16'd0, 0, "mr count0");
    rd(2'd3, 16'd0, 0, "mr status0");
    for (int i = 0; i < 12; i++) rd(2'd3, 16'd0, 0, "mr no done");

    // Drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge Clock);
    #3;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
